// File: rtl/cdb_pkg.sv
// Shared sizing and slice helpers for the common-data-bus arbiter.
// Optional age priority in cdb_arbiter is enabled by defining CDB_AGE_PRIO_EN.
package cdb_pkg;

  localparam int FU_NUM    = 8;
  localparam int WORD_SIZE = 32;
  localparam int RB_SIZE   = 16;
  localparam int RB_INDEX  = 4;
  localparam int FU_INDEX  = $clog2(FU_NUM);

  function automatic logic [RB_INDEX-1:0] fu_rb(input logic [FU_NUM*RB_INDEX-1:0] vec,
                                                input logic [FU_INDEX-1:0]        fu);
    return vec[fu*RB_INDEX +: RB_INDEX];
  endfunction

  function automatic logic [WORD_SIZE-1:0] fu_data(input logic [FU_NUM*WORD_SIZE-1:0] vec,
                                                   input logic [FU_INDEX-1:0]         fu);
    return vec[fu*WORD_SIZE +: WORD_SIZE];
  endfunction

  // Distance from the slot just after the head; smaller means older.
  function automatic logic [RB_INDEX-1:0] age_dist(input logic [RB_INDEX-1:0] rb,
                                                   input logic [RB_INDEX-1:0] head);
    return rb - head - RB_INDEX'(1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_pick
  import cdb_pkg::*;
(
  input  logic [FU_NUM-1:0]   req_i,
  input  logic [FU_INDEX-1:0] ptr_i,
  output logic [FU_NUM-1:0]   gnt_o,
  output logic [FU_INDEX-1:0] idx_o
);

  always_comb begin : pick
    logic found;
    int   pos;
    // NOTE: every comb output gets a default up front so no path infers a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < FU_NUM; k++) begin
      pos = (int'(ptr_i) + k) % FU_NUM;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = FU_INDEX'(pos);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one FU broadcast per cycle onto the per-RB-slot bus.
// Define CDB_AGE_PRIO_EN for oldest-first selection; default is round-robin.
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic [FU_NUM-1:0]             req,
  input  logic [FU_NUM*RB_INDEX-1:0]    req_rb,
  input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
  input  logic [FU_NUM*WORD_SIZE-1:0]   req_addr,
  input  logic [FU_NUM-1:0]             kill,
  input  logic [RB_INDEX-1:0]           rb_head,
  output logic [FU_NUM-1:0]             gnt,
  output logic [RB_SIZE-1:0]            CDB_data_valid,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_data,
  output logic [RB_SIZE*WORD_SIZE-1:0]  CDB_data_addr,
  output logic [FU_NUM-1:0]             cdb_fu
);

  logic [FU_NUM-1:0]            elig, pick_gnt;
  logic [FU_INDEX-1:0]          win, rr_ptr_q, rr_ptr_d;
  logic [RB_INDEX-1:0]          win_rb;
  logic                         xfer;
  logic [RB_SIZE-1:0]           valid_q, valid_d;
  logic [RB_SIZE*WORD_SIZE-1:0] data_q, data_d, addr_q, addr_d;
  logic [FU_NUM-1:0]            fu_q, fu_d;

  assign elig = req & ~kill;

`ifdef CDB_AGE_PRIO_EN
  // Scanning in round-robin order with a strict compare lets rr_ptr break ties.
  always_comb begin : age_pick
    logic                found;
    int                  pos;
    logic [RB_INDEX-1:0] best, dist;
    pick_gnt = '0;
    win      = '0;
    found    = 1'b0;
    best     = '0;
    dist     = '0;
    pos      = 0;
    for (int k = 0; k < FU_NUM; k++) begin
      pos  = (int'(rr_ptr_q) + k) % FU_NUM;
      dist = age_dist(fu_rb(req_rb, FU_INDEX'(pos)), rb_head);
      if (elig[pos] && (!found || dist < best)) begin
        found = 1'b1;
        best  = dist;
        win   = FU_INDEX'(pos);
      end
    end
    if (found) pick_gnt[win] = 1'b1;
  end
`else
  rr_pick u_rr_pick (
    .req_i (elig),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (win)
  );

  logic unused_rb_head;
  assign unused_rb_head = ^rb_head;
`endif

  assign gnt    = reset ? '0 : pick_gnt;
  assign xfer   = |gnt;
  assign win_rb = fu_rb(req_rb, win);

  always_comb begin
    valid_d  = '0;
    data_d   = '0;
    addr_d   = '0;
    fu_d     = '0;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      valid_d[win_rb]                      = 1'b1;
      data_d[win_rb*WORD_SIZE +: WORD_SIZE] = fu_data(req_data, win);
      addr_d[win_rb*WORD_SIZE +: WORD_SIZE] = fu_data(req_addr, win);
      fu_d                                 = gnt;
      rr_ptr_d                             = FU_INDEX'((int'(win) + 1) % FU_NUM);
    end
  end

  // NOTE: the wide data/addr registers are reset too, since consumers read them as zero out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      fu_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values together.
      valid_q  <= valid_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      fu_q     <= fu_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // A squash of the unit currently on the bus hides its result without waiting for an edge.
  assign CDB_data_valid = (|(kill & fu_q)) ? '0 : valid_q;
  assign CDB_data_data  = data_q;
  assign CDB_data_addr  = addr_q;
  assign cdb_fu         = fu_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (round-robin default, age mode under CDB_AGE_PRIO_EN).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic                         clk, reset;
  logic [FU_NUM-1:0]            req, kill, gnt, cdb_fu;
  logic [FU_NUM*RB_INDEX-1:0]   req_rb;
  logic [FU_NUM*WORD_SIZE-1:0]  req_data, req_addr;
  logic [RB_INDEX-1:0]          rb_head;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data, CDB_data_addr;

  int checks   = 0;
  int failures = 0;
  int grant_cnt [FU_NUM];

  cdb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .req_rb         (req_rb),
    .req_data       (req_data),
    .req_addr       (req_addr),
    .kill           (kill),
    .rb_head        (rb_head),
    .gnt            (gnt),
    .CDB_data_valid (CDB_data_valid),
    .CDB_data_data  (CDB_data_data),
    .CDB_data_addr  (CDB_data_addr),
    .cdb_fu         (cdb_fu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [RB_SIZE*WORD_SIZE-1:0] obs,
                     input logic [RB_SIZE*WORD_SIZE-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RB_SIZE*WORD_SIZE-1:0] slot(input int s, input logic [WORD_SIZE-1:0] v);
    logic [RB_SIZE*WORD_SIZE-1:0] r;
    r = '0;
    r[s*WORD_SIZE +: WORD_SIZE] = v;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [RB_INDEX-1:0] rb,
                        input logic [WORD_SIZE-1:0] d, input logic [WORD_SIZE-1:0] a);
    req_rb[i*RB_INDEX +: RB_INDEX]     = rb;
    req_data[i*WORD_SIZE +: WORD_SIZE] = d;
    req_addr[i*WORD_SIZE +: WORD_SIZE] = a;
  endtask

  task automatic check_bus(input string tag, input logic [RB_SIZE-1:0] v, input logic [FU_NUM-1:0] fu,
                           input int s, input logic [WORD_SIZE-1:0] d, input logic [WORD_SIZE-1:0] a);
    chk({tag, "_valid"}, CDB_data_valid, v);
    chk({tag, "_fu"},    cdb_fu, fu);
    chk({tag, "_data"},  CDB_data_data, slot(s, d));
    chk({tag, "_addr"},  CDB_data_addr, slot(s, a));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, CDB_data_valid, '0);
    chk({tag, "_fu"},    cdb_fu, '0);
    chk({tag, "_data"},  CDB_data_data, '0);
    chk({tag, "_addr"},  CDB_data_addr, '0);
  endtask

  initial begin
    reset = 1'b1; req = '0; kill = '0; req_rb = '0; req_data = '0; req_addr = '0; rb_head = '0;
    foreach (grant_cnt[i]) grant_cnt[i] = 0;

    // Reset state: grant suppressed even with a request present.
    #2; req = 8'h01; #1;
    chk("reset_gnt", gnt, '0);
    check_idle("reset");
    req = '0;
    @(negedge clk); reset = 1'b0;
    tick();

    // Reset mid-broadcast, then the pointer is back at FU0.
    set_fu(2, 4'd5, 32'hAB, 32'h11);
    req = 8'h04; #1;
    chk("rst_mid_gnt", gnt, 8'h04);
    tick();
    check_bus("rst_mid_bus", 16'h0020, 8'h04, 5, 32'hAB, 32'h11);
    req = '0; reset = 1'b1; #1;
    check_idle("rst_mid_clear");
    #1; reset = 1'b0;
    set_fu(4, 4'd6, 32'hCD, 32'h22);
    req = 8'h14; #1;
    chk("rst_ptr_gnt", gnt, 8'h04);
    tick();
    check_bus("rst_ptr_fu2", 16'h0020, 8'h04, 5, 32'hAB, 32'h11);
    req = 8'h10; #1;
    chk("rst_ptr_gnt4", gnt, 8'h10);
    tick();
    check_bus("rst_ptr_fu4", 16'h0040, 8'h10, 6, 32'hCD, 32'h22);
    req = '0;
    tick();
    check_idle("hold_one_cycle");

    // Single request: same-cycle grant, one-edge latency, one-cycle hold.
    set_fu(3, 4'd7, 32'h1234, 32'h40);
    req = 8'h08; #1;
    chk("single_gnt", gnt, 8'h08);
    tick();
    check_bus("single_bus", 16'h0080, 8'h08, 7, 32'h1234, 32'h40);
    req = '0;
    tick();
    check_idle("single_clear");

    // Fairness from a fresh pointer: FU0..FU7 twice with no idle cycle.
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < FU_NUM; i++) set_fu(i, RB_INDEX'(i), 32'h100 + i, 32'h200 + i);
    req = 8'hFF;
    for (int c = 0; c < 2 * FU_NUM; c++) begin
      #1;
      chk("fair_gnt", gnt, 8'h01 << (c % FU_NUM));
      for (int i = 0; i < FU_NUM; i++) if (gnt[i]) grant_cnt[i]++;
      tick();
      check_bus("fair_bus", 16'h0001 << (c % FU_NUM), 8'h01 << (c % FU_NUM), c % FU_NUM,
                32'h100 + (c % FU_NUM), 32'h200 + (c % FU_NUM));
    end
    req = '0;
    for (int i = 0; i < FU_NUM; i++) chk("fair_count", grant_cnt[i], 2);
    tick();
    check_idle("fair_clear");

    // Kill: skipped requester, then output gating of the unit on the bus.
    req = 8'h06; kill = 8'h02; #1;
    chk("kill_gnt", gnt, 8'h04);
    tick();
    check_bus("kill_bus", 16'h0004, 8'h04, 2, 32'h102, 32'h202);
    req = '0; kill = 8'h04; #1;
    chk("kill_gate_valid", CDB_data_valid, '0);
    chk("kill_gate_data", CDB_data_data, slot(2, 32'h102));
    chk("kill_gate_fu", cdb_fu, 8'h04);
    kill = '0; #1;
    chk("kill_ungate_valid", CDB_data_valid, 16'h0004);
    tick();
    check_idle("kill_clear");

    // Sole killed requester is not granted.
    req = 8'h01; kill = 8'h01; #1;
    chk("kill_only_gnt", gnt, '0);
    tick();
    check_idle("kill_only_bus");
    req = '0; kill = '0;

    // Back-to-back from a sole requester (pointer is 3 here).
    set_fu(5, 4'd1, 32'h501, 32'h601);
    req = 8'h20; #1;
    chk("b2b_gnt1", gnt, 8'h20);
    tick();
    check_bus("b2b_1", 16'h0002, 8'h20, 1, 32'h501, 32'h601);
    set_fu(5, 4'd2, 32'h502, 32'h602); #1;
    chk("b2b_gnt2", gnt, 8'h20);
    tick();
    check_bus("b2b_2", 16'h0004, 8'h20, 2, 32'h502, 32'h602);
    set_fu(5, 4'd3, 32'h503, 32'h603);
    tick();
    check_bus("b2b_3", 16'h0008, 8'h20, 3, 32'h503, 32'h603);
    req = '0;
    tick();
    check_idle("b2b_clear");

    // FU7 wins alone, leaving the pointer at 0.
    set_fu(7, 4'd9, 32'h777, 32'h778);
    req = 8'h80; #1;
    chk("fu7_gnt", gnt, 8'h80);
    tick();
    check_bus("fu7_bus", 16'h0200, 8'h80, 9, 32'h777, 32'h778);
    req = '0;
    tick();

    // FU1 rb=2 vs FU6 rb=15 with head 14: distances 3 and 0.
    rb_head = 4'd14;
    set_fu(1, 4'd2,  32'h111, 32'h112);
    set_fu(6, 4'd15, 32'h666, 32'h667);
    req = 8'h42; #1;
`ifdef CDB_AGE_PRIO_EN
    chk("age_gnt1", gnt, 8'h40);
    tick();
    check_bus("age_1", 16'h8000, 8'h40, 15, 32'h666, 32'h667);
    req = 8'h02; #1;
    chk("age_gnt2", gnt, 8'h02);
    tick();
    check_bus("age_2", 16'h0004, 8'h02, 2, 32'h111, 32'h112);
`else
    chk("rr_gnt1", gnt, 8'h02);
    tick();
    check_bus("rr_1", 16'h0004, 8'h02, 2, 32'h111, 32'h112);
    req = 8'h40; #1;
    chk("rr_gnt2", gnt, 8'h40);
    tick();
    check_bus("rr_2", 16'h8000, 8'h40, 15, 32'h666, 32'h667);
`endif
    req = '0;
    tick();
    check_idle("final_clear");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among all functional units (adders, multipliers, loaders, storers, branch).
- Each unit requests to broadcast its result, tagged with its reorder-buffer index. The arbiter grants one unit per cycle.
- Registers the winner's payload onto the per-RB-slot bus format that the reorder buffer and reservation stations consume.
- Honours the branch-mispredict kill mask, so squashed units never broadcast.

Parameters:
- FU_NUM, 8, number of requesting functional units.
- WORD_SIZE, 32, data/address width.
- RB_SIZE, 16, reorder-buffer entries.
- RB_INDEX, 4, width of an RB index; clog2(RB_SIZE).

Ports:
- clk  input  1  clock, posedge active.
- reset  input  1  asynchronous, active-high reset.
- req  input  FU_NUM  per-FU broadcast request, held until granted.
- req_rb  input  FU_NUM*RB_INDEX  RB index of each request; FU i occupies slice i.
- req_data  input  FU_NUM*WORD_SIZE  result value per FU.
- req_addr  input  FU_NUM*WORD_SIZE  store/branch address per FU.
- kill  input  FU_NUM  per-FU squash (the reorder buffer's reset_out).
- rb_head  input  RB_INDEX  current RB head; used only with CDB_AGE_PRIO_EN.
- gnt  output  FU_NUM  combinational one-hot grant.
- CDB_data_valid  output  RB_SIZE  registered; one-hot at the winning RB slot.
- CDB_data_data  output  RB_SIZE*WORD_SIZE  registered; winner's data at slot req_rb, all other slots 0.
- CDB_data_addr  output  RB_SIZE*WORD_SIZE  registered; same placement as CDB_data_data.
- cdb_fu  output  FU_NUM  registered one-hot of the broadcasting FU (debug/kill tracking).

Behaviour:
- Reset (asynchronous, any time): CDB_data_valid=0, CDB_data_data=0, CDB_data_addr=0, cdb_fu=0, rr_ptr=0. gnt is 0 while reset is high. A request pending at reset is not remembered.
- Eligibility: elig = req & ~kill.
- Grant (combinational, same cycle): gnt = one-hot of the first set bit in elig, scanning rr_ptr, rr_ptr+1, ... mod FU_NUM. gnt=0 if elig=0.
- Handshake: a transfer happens at a posedge where req[i]&gnt[i].
  - The requester drops req (or presents its next result) in the following cycle.
  - Payload must stay stable while req is high and ungranted.
- Capture at a transfer edge:
  - CDB_data_valid = 1<<req_rb[w].
  - Slot req_rb[w] of CDB_data_data/CDB_data_addr = the winner's data/addr.
  - cdb_fu = 1<<w.
  - rr_ptr = (w+1) mod FU_NUM.
- Latency: exactly one edge from grant to bus valid. The bus holds for exactly one cycle; with no transfer at the next edge, all outputs clear to 0.
- Throughput: one broadcast per cycle, back-to-back allowed. The same FU may win consecutive cycles only if it is the sole eligible requester.
- Fairness: with all FU_NUM units requesting continuously, each is granted exactly once per FU_NUM cycles.
- Kill:
  - A killed FU is never granted in the cycle kill is high.
  - If kill & cdb_fu is nonzero while a broadcast is on the bus, CDB_data_valid clears asynchronously-combinationally at the output gate (data buses unchanged), so consumers see no result from the squashed unit.
  - rr_ptr is not affected by kill.
- Ignored requests: duplicate req_rb values across FUs are a protocol violation and produce no defined priority. Out-of-range req_rb (>=RB_SIZE) is masked to the low RB_INDEX bits.

Optional Feature:
- CDB_AGE_PRIO_EN defined: the winner is the eligible FU whose age distance, (req_rb - rb_head - 1) mod RB_SIZE computed in RB_INDEX bits, is smallest (oldest instruction first). rr_ptr still updates but is used only to break equal distances, which are impossible under the protocol.
- CDB_AGE_PRIO_EN undefined: pure round-robin; rb_head is unused.

Decomposition:
- Shared package cdb_pkg:
  - FU_NUM, RB_SIZE, RB_INDEX, WORD_SIZE.
  - FU slice helpers (fu_rb, fu_data).
  - The age-distance function.
- One sub-module, rr_pick: a FU_NUM-wide rotating priority picker (req vector + pointer -> one-hot grant + encoded index). It is instantiated once; bypassed under CDB_AGE_PRIO_EN.

Test Plan:
- Reset mid-broadcast: FU2 granted with req_rb=5, data=0xAB, then reset pulses at the next edge+0.3 -> all outputs 0 immediately; rr_ptr=0, so the next grant with req=0x04 goes to FU2.
- Single request: req=0x08, req_rb[3]=7, data=0x1234, addr=0x40 -> gnt=0x08 same cycle; next cycle CDB_data_valid=0x0080, slot 7 holds 0x1234/0x40; the cycle after, CDB_data_valid=0.
- All-request fairness: req=0xFF held 16 cycles, unique rb 0..7 -> grants FU0..FU7, FU0..FU7 in order; each FU twice; no idle cycle.
- Kill: req=0x06, kill=0x02 -> gnt=0x04. Then, with FU2 on the bus, kill=0x04 asserted -> CDB_data_valid=0 that cycle.
- Back-to-back same FU: only FU5 requests for 3 cycles with rb 1, 2, 3 -> three consecutive one-hot valids 0x0002, 0x0004, 0x0008.
- CDB_AGE_PRIO_EN: rb_head=14, FU1 rb=2, FU6 rb=15 -> FU6 granted (distance 0 vs 3), then FU1.
